// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   DIV_WIDTH   operand/result width, also imported by the execute stage
//   DIV_ITER    restoring steps per division
//   WORK_W      width of the working register {partial remainder, quotient}
//   div_state_t controller states
//   abs_val     magnitude of an operand, honouring the signed/unsigned mode
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int WORK_W    = 2 * DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] abs_val(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 is_signed
  );
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   work      current working register {remainder[32:0], quotient[31:0]}
//   divisor   divisor magnitude
//   work_next working register after shift / compare / conditional subtract
module div_step
  import div_pkg::*;
(
  input  logic [WORK_W-1:0]    work,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [WORK_W-1:0]    work_next
);

  logic [WORK_W-1:0]  shifted;
  logic [DIV_WIDTH:0] upper;
  logic [DIV_WIDTH:0] diff;

  assign shifted = {work[WORK_W-2:0], 1'b0};
  assign upper   = shifted[WORK_W-1:DIV_WIDTH];
  assign diff    = upper - {1'b0, divisor};

  always_comb begin
    work_next = shifted;   // quotient LSB is already 0 after the shift
    if (upper >= {1'b0, divisor}) begin
      work_next = {diff, shifted[DIV_WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// div: multi-cycle signed/unsigned 32-bit divider for the execute stage.
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_divsigned        1 = DIV, 0 = DIVU (sampled with i_divstart)
//   i_dividend/divisor operands (sampled with i_divstart)
//   i_divstart         start request, honoured only while o_div_ready
//   i_annul            pipeline flush, abandons any operation
//   o_div_ready        high in IDLE only
//   o_div_done         one-cycle result-valid pulse
//   o_quotient         quotient (LO), held until the next result
//   o_remainder        remainder (HI), held until the next result
// Build option: define DIV_ZERO_FAST_EN to short-cut a zero divisor through
// BY_ZERO (result 0/0 after two cycles) instead of running 32 iterations.
module div
  import div_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_divsigned,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_divstart,
  input  logic                 i_annul,
  output logic                 o_div_ready,
  output logic                 o_div_done,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder
);

  div_state_t           state_reg;
  logic [5:0]           count_reg;
  logic [WORK_W-1:0]    work_reg;
  logic [WORK_W-1:0]    work_next;
  logic [DIV_WIDTH-1:0] dvsr_reg;
  logic                 neg_q_reg;
  logic                 neg_r_reg;
  logic                 done_reg;
  logic [DIV_WIDTH-1:0] quot_reg;
  logic [DIV_WIDTH-1:0] rem_reg;

  // Raw results of the final step, before sign correction.
  logic [DIV_WIDTH-1:0] q_raw;
  logic [DIV_WIDTH-1:0] r_raw;

  div_step u_step (
    .work      (work_reg),
    .divisor   (dvsr_reg),
    .work_next (work_next)
  );

  assign q_raw = work_next[DIV_WIDTH-1:0];
  assign r_raw = work_next[2*DIV_WIDTH-1:DIV_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      work_reg  <= '0;
      dvsr_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      done_reg  <= 1'b0;
      quot_reg  <= '0;
      rem_reg   <= '0;
    end else if (i_annul) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_divstart) begin
            count_reg <= '0;
            work_reg  <= {{(DIV_WIDTH+1){1'b0}}, abs_val(i_dividend, i_divsigned)};
            dvsr_reg  <= abs_val(i_divisor, i_divsigned);
            neg_q_reg <= i_divsigned & (i_dividend[DIV_WIDTH-1] ^ i_divisor[DIV_WIDTH-1]);
            neg_r_reg <= i_divsigned & i_dividend[DIV_WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            if (i_divisor == '0) state_reg <= BY_ZERO;
            else                 state_reg <= ON;
`else
            state_reg <= ON;
`endif
          end
        end
`ifdef DIV_ZERO_FAST_EN
        BY_ZERO: begin
          quot_reg  <= '0;
          rem_reg   <= '0;
          done_reg  <= 1'b1;
          state_reg <= END;
        end
`endif
        ON: begin
          work_reg  <= work_next;
          count_reg <= count_reg + 6'd1;
          // The last step's output is corrected and registered directly.
          if (count_reg == 6'(DIV_ITER - 1)) begin
            quot_reg  <= neg_q_reg ? (~q_raw + 1'b1) : q_raw;
            rem_reg   <= neg_r_reg ? (~r_raw + 1'b1) : r_raw;
            done_reg  <= 1'b1;
            state_reg <= END;
          end
        end
        END:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_div_ready = (state_reg == IDLE);
  assign o_div_done  = done_reg;
  assign o_quotient  = quot_reg;
  assign o_remainder = rem_reg;

endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div. The stimulus process pushes the expected
// quotient, remainder and done edge for every accepted start; the monitor
// pops and compares whenever o_div_done is seen.
module tb_div;

  logic        clk;
  logic        rst;
  logic        divsigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        divstart;
  logic        annul;
  logic        div_ready;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          done_at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   chk_cnt   = 0;

  div dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_divsigned (divsigned),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .i_divstart  (divstart),
    .i_annul     (annul),
    .o_div_ready (div_ready),
    .o_div_done  (div_done),
    .o_quotient  (quotient),
    .o_remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("done @%0d q=0x%08h r=0x%08h (exp q=0x%08h r=0x%08h @%0d)",
                   cyc, quotient, remainder, e.q, e.r, e.done_at);
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("latency", 32'(cyc), 32'(e.done_at));
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) check(name, 32'(div_ready), 32'd1);
  endtask

  // Issue one start at a negedge; the start edge is cyc+1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    divsigned = s;
    dividend  = a;
    divisor   = b;
    divstart  = 1'b1;
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int lat);
    exp_t e;
    wait_ready("ready_timeout");
    issue(s, a, b);
    e.q = eq; e.r = er; e.done_at = cyc + 1 + lat;
    exp_q.push_back(e);
    $display("start s=%0d a=0x%08h b=0x%08h", s, a, b);
    @(negedge clk);
    divstart = 1'b0;
    check("ready_drop", 32'(div_ready), 32'd0);
    wait_ready("op_timeout");
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1; annul = 1'b0; divstart = 1'b0;
    divsigned = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(div_ready), 32'd1);
    check("rst_done", 32'(div_done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32);
`ifdef DIV_ZERO_FAST_EN
    do_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1);
`else
    do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32);
`endif

    // Annul at iteration 10: no done, ready next cycle, then 9/3.
    issue(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    divstart = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_ready", 32'(div_ready), 32'd1);
    check("annul_done", 32'(div_done), 32'd0);
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 32);

    // Start held high with changing operands: only the first is used.
    issue(1'b0, 32'd20, 32'd6);
    e.q = 32'd3; e.r = 32'd2; e.done_at = cyc + 1 + 32;
    exp_q.push_back(e);
    $display("start held s=0 a=0x%08h b=0x%08h", 32'd20, 32'd6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!div_done) begin
        check("hold_busy", 32'(div_ready), 32'd0);
        dividend = dividend + 32'd13;
        divisor  = divisor + 32'd1;
      end
    end while (!div_done && n < 100);
    divstart = 1'b0;
    @(negedge clk);
    check("hold_ready", 32'(div_ready), 32'd1);
    do_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 32);

    // Reset at iteration 20: everything cleared, no done.
    issue(1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    divstart = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", 32'(div_ready), 32'd1);
    check("mrst_done", 32'(div_done), 32'd0);
    check("mrst_q", quotient, 32'd0);
    check("mrst_r", remainder, 32'd0);

    // Annul together with start in IDLE: stays idle, nothing runs.
    issue(1'b0, 32'd9, 32'd3);
    annul = 1'b1;
    @(negedge clk);
    divstart = 1'b0;
    annul = 1'b0;
    check("annul_start_ready", 32'(div_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("annul_start_q", quotient, 32'd0);

    do_op(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 32);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
